// File: rtl/victim_buffer_nway.sv
// victim_buffer_nway
//   Fully associative, exclusive victim buffer sitting between L1 and L2.
//   On an L1 miss it takes the missing line address plus an optional evicted
//   L1 line. A buffer hit returns the stored line and swaps the evicted line
//   into that slot. A buffer miss installs the evicted line (writing back a
//   dirty LRU victim first) and fetches the requested line from L2. Fetched
//   lines go straight to L1 and are never allocated here.
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   l1_req/l1_addr             L1 miss request (level) and missing line address
//   l1_evict/l1_eaddr/l1_edata/l1_edirty   optional evicted line
//   l1_resp/l1_rdata/l1_rdirty one-cycle response with the returned line
//   l2_read/l2_write/l2_addr/l2_wdata      L2 request (level until l2_resp)
//   l2_rdata/l2_resp           L2 read data and completion
//   hit_cnt/miss_cnt/wb_cnt    saturating statistics counters
module victim_buffer_nway #(
  parameter int ENTRIES = 4,
  parameter int ADDR_W  = 27,
  parameter int LINE_W  = 256,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              l1_req,
  input  logic [ADDR_W-1:0] l1_addr,
  input  logic              l1_evict,
  input  logic [ADDR_W-1:0] l1_eaddr,
  input  logic [LINE_W-1:0] l1_edata,
  input  logic              l1_edirty,
  output logic              l1_resp,
  output logic [LINE_W-1:0] l1_rdata,
  output logic              l1_rdirty,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [CNT_W-1:0]  wb_cnt
);
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] AGE_ONE = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(ENTRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_WB     = 3'd2,
    S_FILL   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d, req_eaddr_q, req_eaddr_d;
  logic [LINE_W-1:0]   req_edata_q, req_edata_d;
  logic                req_evict_q, req_evict_d, req_edirty_q, req_edirty_d;
  logic [IDX_W-1:0]    tgt_q, tgt_d;
  logic [ENTRIES-1:0]  valid_q, valid_d, dirty_q, dirty_d;
  logic [ADDR_W-1:0]   tag_q [ENTRIES];
  logic [ADDR_W-1:0]   tag_d [ENTRIES];
  logic [LINE_W-1:0]   data_q [ENTRIES];
  logic [LINE_W-1:0]   data_d [ENTRIES];
  logic [IDX_W-1:0]    age_q [ENTRIES];
  logic [IDX_W-1:0]    age_d [ENTRIES];
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic                rdirty_q, rdirty_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, wb_cnt_q, wb_cnt_d;
  logic                l1_resp_q, l1_resp_d, l2_read_q, l2_read_d, l2_write_q, l2_write_d;
  logic [ADDR_W-1:0]   l2_addr_q, l2_addr_d;
  logic [LINE_W-1:0]   l2_wdata_q, l2_wdata_d;

  logic                hit_any_s, hit_s, ematch_s, inv_s, install_s;
  logic [IDX_W-1:0]    hit_idx_s, ematch_idx_s, inv_idx_s, lru_idx_s, inst_idx_s;

  // Associative search: request tag, evict tag, lowest free slot and LRU slot.
  always_comb begin
    hit_any_s    = 1'b0;
    hit_idx_s    = {IDX_W{1'b0}};
    ematch_s     = 1'b0;
    ematch_idx_s = {IDX_W{1'b0}};
    inv_s        = 1'b0;
    inv_idx_s    = {IDX_W{1'b0}};
    lru_idx_s    = {IDX_W{1'b0}};
    // Walking downward lets the lowest matching index win.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      hit_idx_s    = (valid_q[i] && tag_q[i] == req_addr_q) ? IDX_W'(i) : hit_idx_s;
      hit_any_s    = hit_any_s | (valid_q[i] && tag_q[i] == req_addr_q);
      ematch_idx_s = (valid_q[i] && tag_q[i] == req_eaddr_q) ? IDX_W'(i) : ematch_idx_s;
      ematch_s     = ematch_s | (valid_q[i] && tag_q[i] == req_eaddr_q);
      inv_idx_s    = !valid_q[i] ? IDX_W'(i) : inv_idx_s;
      inv_s        = inv_s | !valid_q[i];
      lru_idx_s    = (age_q[i] == AGE_MAX) ? IDX_W'(i) : lru_idx_s;
    end
    // Evicting the very line being requested forces the miss path.
    hit_s = hit_any_s && !(req_evict_q && (req_eaddr_q == req_addr_q));
  end

  // Next-state, buffer update and registered-output computation.
  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    req_eaddr_d  = req_eaddr_q;
    req_edata_d  = req_edata_q;
    req_evict_d  = req_evict_q;
    req_edirty_d = req_edirty_q;
    tgt_d        = tgt_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    data_d       = data_q;
    age_d        = age_q;
    rdata_d      = rdata_q;
    rdirty_d     = rdirty_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    wb_cnt_d     = wb_cnt_q;
    install_s    = 1'b0;
    inst_idx_s   = tgt_q;

    case (state_q)
      S_IDLE: begin
        if (l1_req) begin
          req_addr_d   = l1_addr;
          req_evict_d  = l1_evict;
          req_eaddr_d  = l1_eaddr;
          req_edata_d  = l1_edata;
          req_edirty_d = l1_edirty;
          state_d      = S_LOOKUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOOKUP: begin
        if (hit_s) begin
          rdata_d   = data_q[hit_idx_s];
          rdirty_d  = dirty_q[hit_idx_s];
          hit_cnt_d = sat_inc(hit_cnt_q);
          state_d   = S_RESP;
          if (req_evict_q) begin
            install_s  = 1'b1;
            inst_idx_s = hit_idx_s;
          end else begin
            valid_d[hit_idx_s] = 1'b0;
          end
        end else begin
          miss_cnt_d = sat_inc(miss_cnt_q);
          if (!req_evict_q) begin
            state_d = S_FILL;
          end else begin
            tgt_d = ematch_s ? ematch_idx_s : (inv_s ? inv_idx_s : lru_idx_s);
            // Only a valid dirty LRU victim needs a write-back; an address
            // match is simply overwritten.
            if (!ematch_s && !inv_s && dirty_q[lru_idx_s]) begin
              state_d = S_WB;
            end else begin
              install_s  = 1'b1;
              inst_idx_s = tgt_d;
              state_d    = S_FILL;
            end
          end
        end
      end
      S_WB: begin
        if (l2_resp) begin
          install_s  = 1'b1;
          inst_idx_s = tgt_q;
          wb_cnt_d   = sat_inc(wb_cnt_q);
          state_d    = S_FILL;
        end else begin
          state_d = S_WB;
        end
      end
      S_FILL: begin
        if (l2_resp) begin
          rdata_d  = l2_rdata;
          rdirty_d = 1'b0;
          state_d  = S_RESP;
        end else begin
          state_d = S_FILL;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Install the captured evicted line and promote it to MRU: every entry
    // younger than the target ages by one, keeping ages a permutation.
    for (int i = 0; i < ENTRIES; i++) begin
      tag_d[i]   = (install_s && inst_idx_s == IDX_W'(i)) ? req_eaddr_q  : tag_d[i];
      data_d[i]  = (install_s && inst_idx_s == IDX_W'(i)) ? req_edata_q  : data_d[i];
      dirty_d[i] = (install_s && inst_idx_s == IDX_W'(i)) ? req_edirty_q : dirty_d[i];
      valid_d[i] = (install_s && inst_idx_s == IDX_W'(i)) ? 1'b1         : valid_d[i];
      age_d[i]   = (install_s && inst_idx_s == IDX_W'(i)) ? {IDX_W{1'b0}} :
                   (install_s && age_q[i] < age_q[inst_idx_s]) ? age_q[i] + AGE_ONE : age_q[i];
    end

    // Outputs are decoded from the next state so they leave a flop directly.
    l1_resp_d  = (state_d == S_RESP);
    l2_read_d  = (state_d == S_FILL);
    l2_write_d = (state_d == S_WB);
    l2_addr_d  = (state_d == S_WB)   ? tag_q[tgt_d] :
                 (state_d == S_FILL) ? req_addr_q   : {ADDR_W{1'b0}};
    l2_wdata_d = (state_d == S_WB)   ? data_q[tgt_d] : {LINE_W{1'b0}};
  end

  // State, buffer contents, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      req_addr_q   <= {ADDR_W{1'b0}};
      req_eaddr_q  <= {ADDR_W{1'b0}};
      req_edata_q  <= {LINE_W{1'b0}};
      req_evict_q  <= 1'b0;
      req_edirty_q <= 1'b0;
      tgt_q        <= {IDX_W{1'b0}};
      valid_q      <= {ENTRIES{1'b0}};
      dirty_q      <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]  <= {ADDR_W{1'b0}};
        data_q[i] <= {LINE_W{1'b0}};
        age_q[i]  <= IDX_W'(i);
      end
      rdata_q    <= {LINE_W{1'b0}};
      rdirty_q   <= 1'b0;
      hit_cnt_q  <= {CNT_W{1'b0}};
      miss_cnt_q <= {CNT_W{1'b0}};
      wb_cnt_q   <= {CNT_W{1'b0}};
      l1_resp_q  <= 1'b0;
      l2_read_q  <= 1'b0;
      l2_write_q <= 1'b0;
      l2_addr_q  <= {ADDR_W{1'b0}};
      l2_wdata_q <= {LINE_W{1'b0}};
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      req_eaddr_q  <= req_eaddr_d;
      req_edata_q  <= req_edata_d;
      req_evict_q  <= req_evict_d;
      req_edirty_q <= req_edirty_d;
      tgt_q        <= tgt_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
      age_q        <= age_d;
      rdata_q      <= rdata_d;
      rdirty_q     <= rdirty_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      wb_cnt_q     <= wb_cnt_d;
      l1_resp_q    <= l1_resp_d;
      l2_read_q    <= l2_read_d;
      l2_write_q   <= l2_write_d;
      l2_addr_q    <= l2_addr_d;
      l2_wdata_q   <= l2_wdata_d;
    end
  end

  assign l1_resp   = l1_resp_q;
  assign l1_rdata  = rdata_q;
  assign l1_rdirty = rdirty_q;
  assign l2_read   = l2_read_q;
  assign l2_write  = l2_write_q;
  assign l2_addr   = l2_addr_q;
  assign l2_wdata  = l2_wdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;
  assign wb_cnt    = wb_cnt_q;
endmodule
